mem_stage: RTL

- Memory-access stage plus MEM/WB pipeline register; sits between the EX/MEM register and the writeback mux stage.
- Owns the byte-addressable data memory: word, halfword and byte loads/stores, with load sign/zero extension.
- Registers load data, ALU result, return PC and writeback controls so the writeback stage sees them one cycle later.
- Provides a debug read port that lets the debug unit dump data memory.

---
 rtl/mem_stage_pkg.sv | 19 +
 rtl/mem_stage_data_memory.sv | 31 +++
 rtl/mem_stage.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory stage: access widths, writeback sources, default widths.
// No logic; constants only.
// Not applicable (no flow control).
package mem_stage_pkg;

    localparam int NB_DATA_DEFAULT = 32;
    localparam int NB_REG_DEFAULT  = 5;

    // Access size encodings; 2'b11 is handled as a word access
    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    // Writeback source encodings carried through mem_to_reg
    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

endpackage

// File: rtl/mem_stage_data_memory.sv
// Word-organised data memory with per-byte write enables and two async read ports.
// Writes land at the rising edge; both reads are combinational.
// No backpressure; the caller gates byte_en to suppress writes.
module data_memory #(
    parameter int NB_DATA     = 32,
    parameter int NB_MEM_ADDR = 5
) (
    input  logic                   clock,
    input  logic [NB_DATA/8-1:0]   byte_en,
    input  logic [NB_MEM_ADDR-1:0] addr,
    input  logic [NB_DATA-1:0]     wdata,
    output logic [NB_DATA-1:0]     rdata,
    input  logic [NB_MEM_ADDR-1:0] debug_addr,
    output logic [NB_DATA-1:0]     debug_data
);

    logic [NB_DATA-1:0] mem [2**NB_MEM_ADDR];

    // Byte-lane write; contents are deliberately not reset
    always_ff @(posedge clock) begin
        for (int i = 0; i < NB_DATA/8; i++) begin
            if (byte_en[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata      = mem[addr];
    assign debug_data = mem[debug_addr];

endmodule

// File: rtl/mem_stage.sv
// Memory access stage plus MEM/WB register: lane steering, load extension, alignment check.
// 1 cycle from inputs to all registered outputs (debug read also 1 cycle).
// enable_i=0 freezes the MEM/WB register and blocks stores; debug read keeps running.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int NB_DATA     = NB_DATA_DEFAULT,
    parameter int NB_MEM_ADDR = 5,
    parameter int NB_PC       = 7,
    parameter int NB_REG      = NB_REG_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable_i,
    input  logic [NB_DATA-1:0]     alu_result_i,
    input  logic [NB_DATA-1:0]     write_data_i,
    input  logic                   mem_read_i,
    input  logic                   mem_write_i,
    input  logic [1:0]             mem_width_i,
    input  logic                   mem_unsigned_i,
    input  logic [1:0]             mem_to_reg_i,
    input  logic                   reg_write_i,
    input  logic [NB_REG-1:0]      write_reg_i,
    input  logic [NB_PC-1:0]       pc_i,
    input  logic [NB_MEM_ADDR-1:0] debug_addr_i,
    output logic [NB_DATA-1:0]     mem_data_o,
    output logic [NB_DATA-1:0]     alu_result_o,
    output logic [NB_PC-1:0]       pc_o,
    output logic [1:0]             mem_to_reg_o,
    output logic                   reg_write_o,
    output logic [NB_REG-1:0]      write_reg_o,
    output logic                   misalign_o,
    output logic [NB_DATA-1:0]     debug_data_o
);

    localparam int NB_LANES = NB_DATA/8;

    logic [NB_MEM_ADDR-1:0] word_idx;
    logic [1:0]             byte_off;
    logic                   misaligned;
    logic                   store_en;
    logic [NB_LANES-1:0]    lane_en;
    logic [NB_LANES-1:0]    mem_be;
    logic [NB_DATA-1:0]     store_data;
    logic [NB_DATA-1:0]     rd_word;
    logic [NB_DATA-1:0]     dbg_word;
    logic [7:0]             ld_byte;
    logic [15:0]            ld_half;
    logic [NB_DATA-1:0]     ld_ext;
    logic [NB_DATA-1:0]     ld_result;

    // Upper address bits are dropped so accesses wrap around the memory
    assign word_idx = alu_result_i[NB_MEM_ADDR+1:2];
    assign byte_off = alu_result_i[1:0];

    // Alignment check, lane enables and replicated store data per access size
    always_comb begin
        misaligned = 1'b0;
        lane_en    = '1;
        store_data = write_data_i;
        case (mem_width_i)
            MEM_BYTE: begin
                lane_en    = NB_LANES'(1) << byte_off;
                store_data = {NB_LANES{write_data_i[7:0]}};
            end
            MEM_HALF: begin
                misaligned = byte_off[0];
                lane_en    = byte_off[1] ? 4'b1100 : 4'b0011;
                store_data = {(NB_LANES/2){write_data_i[15:0]}};
            end
            default: misaligned = (byte_off != 2'b00);
        endcase
    end

    // A store in a reset or frozen cycle, or a misaligned one, must not touch memory
    assign store_en = reset & enable_i & mem_write_i & ~misaligned;
    assign mem_be   = store_en ? lane_en : '0;

    data_memory #(
        .NB_DATA     (NB_DATA),
        .NB_MEM_ADDR (NB_MEM_ADDR)
    ) u_dmem (
        .clock      (clock),
        .byte_en    (mem_be),
        .addr       (word_idx),
        .wdata      (store_data),
        .rdata      (rd_word),
        .debug_addr (debug_addr_i),
        .debug_data (dbg_word)
    );

    // Select the addressed byte/half and extend; a simultaneous store forces zero
    always_comb begin
        ld_byte = rd_word[{byte_off, 3'b000} +: 8];
        ld_half = byte_off[1] ? rd_word[16 +: 16] : rd_word[0 +: 16];
        ld_ext  = rd_word;
        case (mem_width_i)
            MEM_BYTE: ld_ext = {{(NB_DATA-8){ld_byte[7] & ~mem_unsigned_i}}, ld_byte};
            MEM_HALF: ld_ext = {{(NB_DATA-16){ld_half[15] & ~mem_unsigned_i}}, ld_half};
            default:  ld_ext = rd_word;
        endcase
        ld_result = (mem_read_i & ~mem_write_i & ~misaligned) ? ld_ext : '0;
    end

    // MEM/WB register: cleared by reset, held while enable_i is low
    always_ff @(posedge clock) begin
        if (!reset) begin
            mem_data_o   <= '0;
            alu_result_o <= '0;
            pc_o         <= '0;
            mem_to_reg_o <= '0;
            reg_write_o  <= 1'b0;
            write_reg_o  <= '0;
            misalign_o   <= 1'b0;
        end else if (enable_i) begin
            mem_data_o   <= ld_result;
            alu_result_o <= alu_result_i;
            pc_o         <= pc_i;
            mem_to_reg_o <= mem_to_reg_i;
            reg_write_o  <= reg_write_i;
            write_reg_o  <= write_reg_i;
            misalign_o   <= (mem_read_i | mem_write_i) & misaligned;
        end
    end

    // Debug read runs every cycle regardless of pipeline freeze
    always_ff @(posedge clock) begin
        if (!reset) begin
            debug_data_o <= '0;
        end else begin
            debug_data_o <= dbg_word;
        end
    end

endmodule
